// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an LSB-first 8N1 serial framer (8E1 when
// UART_TX_PARITY_EN is defined). All outputs except o_Tx_Ready are registered.
module uart_tx #(
  parameter int CLKS_PER_BIT    = 87,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int               DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam int               CNT_W      = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [15:0]      LAST_CLK   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       push;
  logic                       pop;
  logic                       fifo_empty;

  assign o_Tx_Ready = (count != FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = i_Tx_DV && o_Tx_Ready;

  // NOTE: storage is deliberately not reset; an entry is only read after
  // count says it was written, so resetting it would just add reset fan-out.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- framer
  tx_state_e   state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q;
  logic        done_d;
  logic        serial_d;
  logic        active_d;
  logic        bit_end;

  assign bit_end = (clk_cnt_q == LAST_CLK);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      if (pop) data_q <= mem[rd_ptr];
      o_Tx_Serial <= serial_d;
      o_Tx_Active <= active_d;
      o_Tx_Done   <= done_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          // Chain straight into the next start bit when a byte is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // Line level is decoded from the upcoming state so the registered pin
  // changes on the same edge as the state transition.
  always_comb begin
    serial_d = 1'b1;
    active_d = (state_d != IDLE);
    unique case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = data_q[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = ^data_q;
`endif
      default: serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle comparison of all outputs against
// a timeline model of queued frames (start edge, byte), directed plus random.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int LOG2  = 2;
  localparam int DEPTH = 1 << LOG2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  typedef struct {
    int         acc;
    int         start;
    logic [7:0] data;
  } frame_t;

  frame_t frames[$];

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv    = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       tx_ready, tx_serial, tx_active, tx_done;

  int n_checks  = 0;
  int n_errors  = 0;
  int edge_n    = 0;
  int done_seen = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Tx_DV    (dv),
    .i_Tx_Byte  (din),
    .o_Tx_Ready (tx_ready),
    .o_Tx_Serial(tx_serial),
    .o_Tx_Active(tx_active),
    .o_Tx_Done  (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Expected line level in the cycle following edge e.
  function automatic logic exp_line(input int e);
    int slot;
    foreach (frames[i]) begin
      if (e >= frames[i].start && e < frames[i].start + FRAME) begin
        slot = (e - frames[i].start) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return frames[i].data[slot-1];
        if (slot == 9 && NBITS == 11) return ^frames[i].data;
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_active(input int e);
    foreach (frames[i])
      if (e >= frames[i].start && e < frames[i].start + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_done(input int e);
    foreach (frames[i])
      if (frames[i].start + FRAME == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_count(input int e);
    int n = 0;
    foreach (frames[i])
      if (frames[i].acc <= e && frames[i].start > e) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("serial", 32'(tx_serial), 32'(exp_line(edge_n)));
    check("active", 32'(tx_active), 32'(exp_active(edge_n)));
    check("done",   32'(tx_done),   32'(exp_done(edge_n)));
    check("ready",  32'(tx_ready),  32'(exp_count(edge_n) < DEPTH));
  endtask

  // One clock cycle: drive, advance model on acceptance, sample #1 after edge.
  task automatic step(input logic v, input logic [7:0] b, output logic accepted);
    frame_t nf;
    int     last_end;
    dv = v;
    din = b;
    accepted = v && rst_n && (exp_count(edge_n) < DEPTH);
    @(posedge clk);
    edge_n++;
    if (accepted) begin
      last_end = 0;
      if (frames.size() > 0) last_end = frames[$].start + FRAME;
      nf.acc   = edge_n;
      nf.start = (edge_n + 1 > last_end) ? edge_n + 1 : last_end;
      nf.data  = b;
      frames.push_back(nf);
    end
    #1;
    check_outputs();
    if (tx_done) done_seen++;
    dv = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) step(1'b0, 8'h00, acc);
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int   budget = 4 * FRAME * DEPTH;
    acc = 1'b0;
    while (!acc && budget > 0) begin
      step(1'b1, b, acc);
      budget--;
    end
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int remain;
    remain = 5;
    if (frames.size() > 0) remain = frames[$].start + FRAME - edge_n + 5;
    if (remain < 5) remain = 5;
    idle(remain);
  endtask

  task automatic do_reset();
    logic acc;
    rst_n = 1'b0;
    #1;
    check("rst_serial", 32'(tx_serial), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_done",   32'(tx_done),   32'd0);
    check("rst_ready",  32'(tx_ready),  32'd1);
    frames.delete();
    repeat (3) step(1'b0, 8'h00, acc);
    rst_n = 1'b1;
  endtask

  logic [7:0] burst [5] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C};
  int         d0;
  int         t81;

  initial begin
    #2;
    do_reset();
    idle(1000);

    // Single byte: one done pulse at the model-predicted edge.
    d0 = done_seen;
    send(8'hA5);
    drain();
    check("a5_done_pulses", 32'(done_seen - d0), 32'd1);

    // Burst on consecutive cycles fills the FIFO and streams with no gap.
    d0 = done_seen;
    foreach (burst[i]) send(burst[i]);
    check("burst_ready_low", 32'(tx_ready), 32'd0);
    drain();
    check("burst_done_pulses", 32'(done_seen - d0), 32'd5);

    // Parity-relevant bytes (odd and even number of ones).
    send(8'h07);
    send(8'h03);
    drain();

    // Reset during data bit 3 of 0x81 with two bytes queued behind it.
    send(8'h81);
    t81 = frames[$].start;
    send(8'h12);
    send(8'h34);
    while (edge_n < t81 + 4 * CPB + 1) idle(1);
    check("pre_reset_bit3", 32'(tx_serial), 32'd0);
    d0 = done_seen;
    do_reset();
    idle(200);
    check("post_reset_no_done", 32'(done_seen - d0), 32'd0);

    // Random bytes with random gaps, including gapless runs.
    for (int i = 0; i < 40; i++) begin
      idle(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, FRAME + 5));
      send(8'($urandom));
    end
    for (int i = 0; i < 8; i++) send(8'($urandom));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART link: accepts bytes over a valid/ready handshake into a small FIFO and shifts them out as LSB-first asynchronous frames (start bit, 8 data bits, optional even parity, one stop bit). It is the transmit counterpart of the existing receiver, uses the same CLKS_PER_BIT bit timing, and drives the board serial TX pin from the core clock domain.

## Interface
- CLKS_PER_BIT, 87, core clocks per serial bit (clock freq / baud); legal range 2..65535
- FIFO_DEPTH_LOG2, 2, log2 of FIFO entries (default 4 bytes); legal range 1..4
- i_Clock  in  1  core clock, all logic on rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Tx_DV  in  1  byte valid; write occurs when i_Tx_DV && o_Tx_Ready at a rising edge
- i_Tx_Byte  in  8  byte to send, bit 0 sent first
- o_Tx_Ready  out  1  FIFO not full (combinational from FIFO count)
- o_Tx_Serial  out  1  serial line, registered, idles high
- o_Tx_Active  out  1  high from first cycle of start bit to last cycle of stop bit
- o_Tx_Done  out  1  one-cycle pulse after each stop bit completes

## Operation
- Reset (asserted): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, FIFO empty, o_Tx_Ready=1, state IDLE, counters 0.
- FIFO: circular, read/write pointers FIFO_DEPTH_LOG2 bits wide plus a count of FIFO_DEPTH_LOG2+1 bits; pointers wrap modulo depth. Write while full impossible (ready low). Simultaneous write and pop: count unchanged, both pointers advance.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_Tx_Serial=1. If FIFO non-empty: pop head into shift register, clock count=0, go START.
  - START: o_Tx_Serial=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: o_Tx_Serial=shift[index] for CLKS_PER_BIT cycles per bit; after index 7 go PARITY (macro defined) or STOP.
  - PARITY: o_Tx_Serial = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles. On last cycle: pulse o_Tx_Done; if FIFO non-empty, pop and go directly to START (no idle gap), else IDLE.
- Clock counter counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary; 16 bits wide.
- Data in the shift register is captured at pop; later FIFO writes never affect the frame in flight.
- Reset mid-frame: line returns high immediately (asynchronous), frame truncated, FIFO contents discarded, no o_Tx_Done.

## Timing
- Write accepted at edge k into empty FIFO with state IDLE: pop at edge k+1, o_Tx_Serial low from edge k+1 (1-cycle latency).
- Each bit lasts exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles (11* with parity).
- o_Tx_Done high for the single cycle following the last stop-bit cycle, concurrent with next start bit in back-to-back mode.
- Back-to-back bytes: stop bit of byte n immediately followed by start bit of byte n+1; continuous stream at full baud.
- o_Tx_Ready falls in the cycle after the write that fills the FIFO; rises in the cycle after the pop that frees a slot.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state compiled in, 8E1 frames of 11 bits.
- Undefined: PARITY state and its logic absent, 8N1 frames of 10 bits; DATA goes straight to STOP.

## Test plan
- Reset, no writes -> o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0 for 1000 cycles.
- CLKS_PER_BIT=4, write 0xA5 -> line low at next edge, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, stop high 4 cycles, o_Tx_Done one pulse at cycle 40 after start.
- Write 0x00,0xFF,0x55,0xAA,0x3C on consecutive cycles (depth 4) -> o_Tx_Ready low while 4 entries queued, all five bytes sent back-to-back, no idle gap, five o_Tx_Done pulses 40 cycles apart.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frames 44 cycles at CLKS_PER_BIT=4.
- Assert i_Rst_n low during DATA bit 3 of 0x81 with two bytes queued -> o_Tx_Serial=1 immediately, FIFO empty, no o_Tx_Done, no further frames after release.
- Loopback through the existing receiver (CLKS_PER_BIT=87, 8N1), 256 bytes 0x00..0xFF -> every byte received identically in order.
